// File: rtl/sipo_frame_rx_if.sv
// Beat-in / frame-out handshake bundle for sipo_frame_rx.
// The slave modport is the receiver's view; the master modport is the
// view of whatever sits around it (upstream source plus downstream sink).
interface sipo_frame_rx_if #(
    parameter int BIT   = 8,
    parameter int NDATA = 3
);
    // Upstream beat stream
    logic                          i_valid;
    logic                          o_ready;
    logic [BIT-1:0]                i_data;
    logic                          i_last;

    // Downstream frame stream; element 0 is the first beat of the frame
    logic                          o_valid;
    logic                          i_ready;
    logic [0:NDATA-1][BIT-1:0]     o_frame;

    // Malformed-frame reporting
    logic                          o_err;
    logic [7:0]                    o_err_cnt;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_last,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_frame,
        output o_err,
        output o_err_cnt
    );

    modport master (
        output i_valid,
        output i_data,
        output i_last,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_frame,
        input  o_err,
        input  o_err_cnt
    );
endinterface

// File: rtl/sipo_frame_rx.sv
// Serial-in parallel-out frame assembler.
// Packs exactly NDATA beats (the last one flagged by i_last) into a frame,
// offers it downstream, and drops/flags frames that end early or run long.
// While a frame is pending, upstream readiness mirrors downstream readiness
// so a new frame can start in the same cycle the old one leaves.
module sipo_frame_rx #(
    parameter int BIT   = 8,
    parameter int NDATA = 3
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sipo_frame_rx_if.slave bus
);
    localparam int            CW       = (NDATA > 1) ? $clog2(NDATA) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NDATA - 1);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        FULL    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [CW-1:0]   cnt_reg;
    logic [CW-1:0]   cnt_next;
    logic [CW-1:0]   wr_slot;
    logic            wr_en;
    logic            err_reg;
    logic            err_next;
    logic [7:0]      err_cnt_reg;
    logic            ready;
    logic            accept;
    logic [BIT-1:0]  frame_reg [NDATA];

    // Upstream ready: held low during reset, and in FULL only when the
    // pending frame is leaving this cycle.
    always_comb begin
        ready = 1'b0;
        if (!i_rst) begin
            case (state_reg)
                COLLECT: ready = 1'b1;
                DISCARD: ready = 1'b1;
                FULL:    ready = bus.i_ready;
                default: ready = 1'b0;
            endcase
        end
    end

    assign accept = bus.i_valid && ready;

    // Next-state, beat counter, slot write enable and error pulse.
    // FULL with an incoming beat behaves like COLLECT starting at slot 0.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        wr_en      = 1'b0;
        wr_slot    = cnt_reg;
        err_next   = 1'b0;
        case (state_reg)
            COLLECT, FULL: begin
                if (state_reg == FULL) begin
                    wr_slot = '0;
                    if (bus.i_ready) begin
                        state_next = COLLECT;
                    end
                end
                if (accept) begin
                    wr_en = 1'b1;
                    if (wr_slot == LAST_IDX) begin
                        // Slot NDATA-1 filled: i_last decides good vs. long
                        cnt_next   = '0;
                        state_next = bus.i_last ? FULL : DISCARD;
                        err_next   = !bus.i_last;
                    end else if (bus.i_last) begin
                        // Frame ended before all slots were filled
                        cnt_next   = '0;
                        state_next = COLLECT;
                        err_next   = 1'b1;
                    end else begin
                        cnt_next   = wr_slot + 1'b1;
                        state_next = COLLECT;
                    end
                end
            end
            DISCARD: begin
                // Swallow the tail of an over-long frame; it was already flagged
                if (accept && bus.i_last) begin
                    state_next = COLLECT;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = COLLECT;
                cnt_next   = '0;
            end
        endcase
    end

    // State register, beat counter and registered error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= COLLECT;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    // Saturating count of malformed frames.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            err_cnt_reg <= '0;
        end else if (err_next && (err_cnt_reg != 8'hFF)) begin
            err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    // One register per frame slot; a slot only changes when a beat lands in it,
    // so the pending frame is frozen while downstream stalls.
    for (genvar gi = 0; gi < NDATA; gi++) begin : g_slot
        // Capture the accepted beat when it targets this slot.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                frame_reg[gi] <= '0;
            end else if (wr_en && (wr_slot == CW'(gi))) begin
                frame_reg[gi] <= bus.i_data;
            end
        end
    end

    // Present the slot registers as the packed output frame.
    always_comb begin
        bus.o_frame = '0;
        for (int i = 0; i < NDATA; i++) begin
            bus.o_frame[i] = frame_reg[i];
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_valid   = (state_reg == FULL);
    assign bus.o_err     = err_reg;
    assign bus.o_err_cnt = err_cnt_reg;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: a driver issues frames and pushes
// their expected outcome (delivered frame or error count) into queues; an
// independent monitor pops and compares whenever the DUT presents a frame
// transfer or an error pulse.
module tb_sipo_frame_rx;
    localparam int BIT   = 8;
    localparam int NDATA = 3;

    typedef logic [0:NDATA-1][BIT-1:0] frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sipo_frame_rx_if #(.BIT(BIT), .NDATA(NDATA)) bus ();

    sipo_frame_rx #(.BIT(BIT), .NDATA(NDATA)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    frame_t exp_frames[$];
    int     exp_errs[$];
    int     vectors     = 0;
    int     miscompares = 0;
    int     err_model   = 0;
    int     cyc         = 0;
    int     stall_cnt   = 0;
    bit     rand_ready  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every frame transfer and every error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.o_valid && bus.i_ready) begin
                if (exp_frames.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL frame_unexpected: got 0x%0h expected no frame at t=%0t", bus.o_frame, $time);
                end else begin
                    check("frame", 64'(bus.o_frame), 64'(exp_frames.pop_front()));
                end
            end
            if (bus.o_err) begin
                if (exp_errs.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL err_unexpected: got o_err=1 expected 0 at t=%0t", $time);
                end else begin
                    check("err_cnt", 64'(bus.o_err_cnt), 64'(exp_errs.pop_front()));
                end
            end
        end
    end

    // Drive one beat and wait (bounded) until it is accepted.
    task automatic send_beat(input logic [BIT-1:0] d, input bit last);
        bit done  = 1'b0;
        bit first = 1'b1;
        int t     = 0;
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        bus.i_last  = last;
        while (!done) begin
            if (rand_ready) bus.i_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (bus.o_ready) begin
                done = 1'b1;
            end else begin
                if (first) stall_cnt++;
                first = 1'b0;
                t++;
                if (t > 200) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL beat_timeout: got o_ready=0 for %0d cycles expected acceptance", t);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            if (rand_ready) bus.i_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push_err();
        err_model = (err_model < 255) ? err_model + 1 : 255;
        exp_errs.push_back(err_model);
    endfunction

    // Reference model at frame granularity: exactly NDATA beats is a good
    // frame, anything shorter or longer is one error.
    task automatic send_frame(input int len, input int gap_max);
        logic [BIT-1:0] d [];
        frame_t f = '0;
        d = new[len];
        for (int i = 0; i < len; i++) d[i] = BIT'($urandom);
        if (len == NDATA) begin
            for (int i = 0; i < NDATA; i++) f[i] = d[i];
            exp_frames.push_back(f);
        end else begin
            push_err();
        end
        for (int i = 0; i < len; i++) begin
            send_beat(d[i], i == len - 1);
            if (gap_max > 0) idle($urandom_range(0, gap_max));
        end
    endtask

    task automatic drain();
        int t = 0;
        rand_ready  = 1'b0;
        bus.i_ready = 1'b1;
        while ((exp_frames.size() != 0 || exp_errs.size() != 0) && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_pending", 64'(exp_frames.size() + exp_errs.size()), 64'(0));
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready_low", 64'(bus.o_ready), 64'(0));
        @(posedge clk);
        #1;
        rst       = 1'b0;
        err_model = 0;
        exp_frames.delete();
        exp_errs.delete();
        #1;
        check("rst_ready_high", 64'(bus.o_ready), 64'(1));
        check("rst_valid", 64'(bus.o_valid), 64'(0));
        check("rst_err", 64'(bus.o_err), 64'(0));
        check("rst_err_cnt", 64'(bus.o_err_cnt), 64'(0));
        check("rst_frame", 64'(bus.o_frame), 64'(0));
    endtask

    initial begin
        frame_t fa;
        frame_t fb;
        int     c0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        bus.i_last  = 1'b0;
        bus.i_ready = 1'b1;
        do_reset();

        // Basic good frame
        exp_frames.push_back({8'h11, 8'h22, 8'h33});
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b0);
        send_beat(8'h33, 1'b1);
        check("basic_valid", 64'(bus.o_valid), 64'(1));
        idle(1);
        check("basic_one_cycle", 64'(bus.o_valid), 64'(0));

        // Backpressure then same-cycle handoff to the next frame
        fa = {8'hA0, 8'hA1, 8'hA2};
        fb = {8'hB0, 8'hB1, 8'hB2};
        bus.i_ready = 1'b0;
        exp_frames.push_back(fa);
        send_beat(8'hA0, 1'b0);
        send_beat(8'hA1, 1'b0);
        send_beat(8'hA2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_ready", 64'(bus.o_ready), 64'(0));
            check("bp_valid", 64'(bus.o_valid), 64'(1));
            check("bp_frame", 64'(bus.o_frame), 64'(fa));
            @(posedge clk);
            #1;
        end
        exp_frames.push_back(fb);
        bus.i_ready = 1'b1;
        send_beat(8'hB0, 1'b0);
        check("handoff_slot0", 64'(bus.o_frame[0]), 64'(8'hB0));
        check("handoff_valid", 64'(bus.o_valid), 64'(0));
        send_beat(8'hB1, 1'b0);
        send_beat(8'hB2, 1'b1);
        idle(1);

        // Short frame followed by a good frame
        push_err();
        send_beat(8'h01, 1'b0);
        send_beat(8'h02, 1'b1);
        check("short_err", 64'(bus.o_err), 64'(1));
        idle(1);
        check("short_err_pulse", 64'(bus.o_err), 64'(0));
        check("short_err_cnt", 64'(bus.o_err_cnt), 64'(err_model));
        exp_frames.push_back({8'h10, 8'h20, 8'h30});
        send_beat(8'h10, 1'b0);
        send_beat(8'h20, 1'b0);
        send_beat(8'h30, 1'b1);
        idle(1);

        // Long frame: error after the NDATA-th beat, tail swallowed
        push_err();
        send_beat(8'h41, 1'b0);
        send_beat(8'h42, 1'b0);
        check("long_no_err_early", 64'(bus.o_err), 64'(0));
        send_beat(8'h43, 1'b0);
        check("long_err_beat3", 64'(bus.o_err), 64'(1));
        send_beat(8'h44, 1'b0);
        check("long_err_once", 64'(bus.o_err), 64'(0));
        send_beat(8'h45, 1'b1);
        check("long_tail_valid", 64'(bus.o_valid), 64'(0));
        check("long_err_cnt", 64'(bus.o_err_cnt), 64'(err_model));
        send_frame(NDATA, 0);
        drain();

        // Streaming: back-to-back frames, no bubbles
        stall_cnt = 0;
        c0 = cyc;
        for (int i = 0; i < 100; i++) send_frame(NDATA, 0);
        check("stream_cycles", 64'(cyc - c0), 64'(100 * NDATA));
        check("stream_stalls", 64'(stall_cnt), 64'(0));
        drain();

        // Random lengths, gaps and downstream readiness
        rand_ready = 1'b1;
        for (int i = 0; i < 60; i++) send_frame($urandom_range(1, NDATA + 2), 2);
        drain();

        // Reset in the middle of a frame
        send_beat(8'h61, 1'b0);
        send_beat(8'h62, 1'b0);
        do_reset();
        exp_frames.push_back({8'h71, 8'h72, 8'h73});
        send_beat(8'h71, 1'b0);
        send_beat(8'h72, 1'b0);
        send_beat(8'h73, 1'b1);
        drain();

        // Error counter saturation
        for (int i = 0; i < 300; i++) send_frame(1, 0);
        drain();
        check("sat_cnt", 64'(bus.o_err_cnt), 64'(255));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sipo_frame_rx.md
# sipo_frame_rx

Receive-side frame assembler for the beat-serial word streams our PISO-style serializers emit. It accepts BIT-wide beats under a valid/ready handshake with an end-of-frame marker, packs exactly NDATA beats into a parallel frame and presents that frame downstream under a second valid/ready handshake. Malformed frames are dropped and flagged. The block sits between a serial link or serializer output and any parallel consumer.

## Interface
- BIT, 8: beat width in bits.
- NDATA, 3: beats per frame; NDATA >= 1.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  upstream beat valid.
- o_ready  out  1  upstream ready; a beat transfers when i_valid && o_ready at a rising edge.
- i_data  in  BIT  beat payload.
- i_last  in  1  marks the final beat of a frame; qualified by i_valid.
- o_valid  out  1  frame valid.
- i_ready  in  1  downstream ready; a frame transfers when o_valid && i_ready.
- o_frame  out  BIT x [0:NDATA-1]  assembled frame; element 0 is the first beat received.
- o_err  out  1  one-cycle pulse per malformed frame.
- o_err_cnt  out  8  saturating count of malformed frames.

## Operation
- Beat counter cnt has width max(1, clog2(NDATA)) and counts 0..NDATA-1.
- States: COLLECT, FULL, DISCARD.
- COLLECT: o_ready=1. An accepted beat writes i_data into slot cnt.
  - Short frame: i_last=1 with cnt<NDATA-1. The frame is dropped, o_err pulses, cnt becomes 0, state stays COLLECT.
  - Good frame: cnt==NDATA-1 with i_last=1. Go to FULL, cnt becomes 0.
  - Long frame: cnt==NDATA-1 with i_last=0. The frame is dropped, o_err pulses, cnt becomes 0, go to DISCARD.
  - Otherwise cnt increments.
- FULL: o_valid=1 and o_frame holds the completed frame. o_ready = i_ready, giving zero-bubble back-to-back operation.
  - If i_ready=0: o_frame and o_valid hold. No beat is accepted.
  - If i_ready=1 with no incoming beat: go to COLLECT.
  - If i_ready=1 with an incoming beat: the outgoing frame transfers and the beat is written to slot 0 in the same cycle. Next state and cnt follow the COLLECT rules for cnt=0. For NDATA=1 with i_last=1 the block stays in FULL with the new frame.
- DISCARD: o_ready=1, o_valid=0. Beats are consumed and not stored. An accepted beat with i_last=1 returns the block to COLLECT with cnt=0. No further o_err is raised for this frame.
- o_err_cnt increments on every o_err pulse and saturates at 255.
- NDATA=1: every beat must carry i_last. A beat without i_last is a long frame.
- o_frame slots are written only in COLLECT, or in FULL when a beat is accepted. Slots not yet rewritten keep stale data, which is only visible while o_valid=0.

## Timing
- Reset: state COLLECT, cnt 0, o_valid 0, o_err 0, o_err_cnt 0, all o_frame slots 0. o_ready=0 while i_rst=1 and 1 in the first cycle after release.
- Reset mid-frame or in FULL discards the partial or pending frame without raising o_err.
- Latency: o_valid rises in the cycle after the final good beat is accepted.
- Throughput: one beat per cycle sustained when i_ready stays high. A frame every NDATA cycles, with no bubble.
- o_err is registered and is high in the cycle after the offending beat is accepted.
- Upstream is not required to hold i_valid; beats are sampled only on transfer.
- Downstream may toggle i_ready freely. o_frame is stable whenever o_valid=1 and no transfer occurs.

## Test plan
- Basic: NDATA=3, send beats 0x11, 0x22, 0x33(last) with i_ready=1. Required: o_valid high for one cycle and o_frame={0x11,0x22,0x33}.
- Backpressure and handoff: hold i_ready=0 for 5 cycles after frame A {0xA0,0xA1,0xA2}.
  - Required: o_ready=0 and o_frame stable throughout.
  - Raise i_ready while beat 0xB0 is valid. Required: A transfers and 0xB0 lands in slot 0 in the same cycle.
- Short frame: send 0x01, 0x02(last), then good frame 0x10, 0x20, 0x30(last).
  - Required: one o_err pulse, o_err_cnt=1, o_valid never asserted for the short frame.
  - Required: next frame delivered as {0x10,0x20,0x30}.
- Long frame: send 5 beats with last only on the 5th, then a good frame.
  - Required: o_err pulses once, after beat 3.
  - Required: beats 4-5 are discarded, o_err_cnt=1, and the next good frame is delivered intact.
- Streaming: 100 back-to-back random frames with i_ready=1 and i_valid=1. Required: 100 frames out in order, 300 beats in 300 cycles, o_ready never deasserts.
- Reset: assert i_rst after 2 beats of a frame, then send a full frame. Required: the outputs show their reset values, o_err stays 0, and the new frame is delivered correctly. Also check o_err_cnt saturates at 255 after 300 short frames.
